multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Parametrised multi-cycle control sequencer for the accumulator/register CPU.
- Latches the instruction opcode and walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Emits per-cycle datapath strobes and waits on a data-memory ready handshake, with a timeout.
- Provides halt, fault and retired-instruction status. Sits between instruction ROM/IR, data memory, register file and ALU.

Parameters:
- OPW, 4, opcode width.
- ALUW, 3, ALUOp width.
- TIMEOUT, 8, max MEM-state cycles to wait for MemReady before fault (>=2).
- CNTW, 16, retired-instruction counter width.

Ports:
- Clk, input, 1, clock. Single clock, all state on rising edge.
- Reset, input, 1, synchronous active-high reset.
- InstValid, input, 1, Opcode is valid this cycle.
- Opcode, input, OPW, instruction opcode field.
- Zero, input, 1, ALU zero flag.
- MemReady, input, 1, data memory completed the access.
- IRWrite, output, 1, load instruction register.
- PCWrite, output, 1, advance or redirect PC (one pulse per retired instruction).
- Branch, output, 1, select branch target for PC.
- ALUSrc, output, 1, 1 selects immediate as ALU B.
- ALUOp, output, ALUW, ALU operation.
- MemRead, output, 1, data memory read request.
- MemWrite, output, 1, data memory write request.
- MemtoReg, output, 1, 1 selects memory data for register write.
- RegWrite, output, 1, register file write enable.
- Halted, output, 1, halt instruction retired; sticky.
- Fault, output, 1, memory timeout occurred; sticky.
- RetireCnt, output, CNTW, count of PCWrite pulses; wraps.

Behaviour:
- Opcode map (low 4 bits; upper bits must be 0, else NOP):
  - 0000 store; 0001 add; 0010 load; 0011 sub; 0100 and; 0101 xor; 0110 beqz; 0111 addi; 1111 halt; others NOP.
- ALUOp encoding: add 000, sub 001, and 010, xor 011, pass-A 111.
  - load, store and addi use add with ALUSrc=1.
- Registered state: FSM state, op_q, wait counter, Halted, Fault, RetireCnt.
  - Reset sets state=FETCH, op_q=0, wait counter=0, Halted=0, Fault=0, RetireCnt=0.
- Strobe defaults: every strobe is 0 unless listed below; ALUOp=111 except in EXEC/MEM/WB.
  - ALUOp in EXEC/MEM/WB = decode(op_q).
- FETCH:
  - IRWrite=InstValid.
  - InstValid=1: op_q<=Opcode, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - halt: PCWrite=0, go to HALT.
  - NOP: PCWrite=1, go to FETCH.
  - otherwise go to EXEC.
- EXEC:
  - ALU ops: go to WB.
  - load/store: ALUSrc=1, go to MEM, clear wait counter.
  - beqz: Branch=Zero, PCWrite=1, go to FETCH.
- MEM:
  - ALUSrc=1; MemRead=1 (load) or MemWrite=1 (store), held until exit.
  - MemReady=1, load: go to WB.
  - MemReady=1, store: PCWrite=1, go to FETCH.
  - MemReady=0, wait counter == TIMEOUT-1: set Fault, go to FAULT.
  - MemReady=0, otherwise: increment wait counter.
  - MemReady wins over timeout in the same cycle.
- WB:
  - RegWrite=1, PCWrite=1; MemtoReg=1 for load; ALUSrc=1 for addi. Go to FETCH.
- HALT: Halted=1; absorbing until Reset.
- FAULT: Fault=1; absorbing until Reset; no strobes.
- RetireCnt increments on every PCWrite pulse, wrapping from 2^CNTW-1 to 0. Halt does not count.
- Cycle counts from FETCH accept (no memory wait):
  - ALU op: 4.
  - load: 5+waits.
  - store: 4+waits.
  - beqz: 3.
  - NOP: 2.
- Reset mid-instruction (including in MEM with a request asserted): next cycle is FETCH with all strobes low.
  - The pending memory request is dropped and the instruction does not retire.
- InstValid while not in FETCH is ignored. Opcode is sampled only on the FETCH accept edge.

Test Plan:
- Reset, then add (0001) with InstValid=1:
  - IRWrite at cycle 0; RegWrite+PCWrite with ALUOp=000 at cycle 3; back to FETCH; RetireCnt=1.
- load (0010) with MemReady held low 3 cycles, then high:
  - MemRead=1 for 4 cycles with ALUSrc=1; then WB with MemtoReg=1, RegWrite=1; total 8 cycles.
- store (0000) with MemReady never high, TIMEOUT=8:
  - MemWrite high exactly 8 cycles, then Fault=1 sticky and all strobes 0.
  - Reset clears Fault and returns to FETCH.
- beqz (0110) with Zero=1, then Zero=0:
  - Branch=1/PCWrite=1 in EXEC; then Branch=0/PCWrite=1; RetireCnt=2.
- halt (1111) then further InstValid pulses:
  - Halted=1 forever, IRWrite stays 0, RetireCnt unchanged.
- CNTW=2, retire 5 NOPs (1010):
  - each takes 2 cycles; RetireCnt sequence 1,2,3,0,1.
- Reset asserted during MEM of a load:
  - MemRead drops the next cycle, no RegWrite, RetireCnt=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction/memory handshake and datapath strobe bundle for multicycle_control
interface multicycle_control_if #(
  parameter int OPW  = 4,
  parameter int ALUW = 3,
  parameter int CNTW = 16
);
  logic            InstValid;
  logic [OPW-1:0]  Opcode;
  logic            Zero;
  logic            MemReady;
  logic            IRWrite;
  logic            PCWrite;
  logic            Branch;
  logic            ALUSrc;
  logic [ALUW-1:0] ALUOp;
  logic            MemRead;
  logic            MemWrite;
  logic            MemtoReg;
  logic            RegWrite;
  logic            Halted;
  logic            Fault;
  logic [CNTW-1:0] RetireCnt;

  // Controller side: consumes instruction/memory status, drives strobes and status
  modport master (
    input  InstValid, Opcode, Zero, MemReady,
    output IRWrite, PCWrite, Branch, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, Halted, Fault, RetireCnt
  );

  // Datapath/memory side
  modport slave (
    output InstValid, Opcode, Zero, MemReady,
    input  IRWrite, PCWrite, Branch, ALUSrc, ALUOp, MemRead, MemWrite,
           MemtoReg, RegWrite, Halted, Fault, RetireCnt
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module multicycle_control #(
  parameter int OPW     = 4,
  parameter int ALUW    = 3,
  parameter int TIMEOUT = 8,
  parameter int CNTW    = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  multicycle_control_if.master bus
);

  // Wait counter only has to reach TIMEOUT-1, the last MEM cycle before a fault.
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [3:0] OP_STORE = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_BEQZ  = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(3'b000);
  localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(3'b001);
  localparam logic [ALUW-1:0] ALU_AND  = ALUW'(3'b010);
  localparam logic [ALUW-1:0] ALU_XOR  = ALUW'(3'b011);
  localparam logic [ALUW-1:0] ALU_PASS = ALUW'(3'b111);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  state_t          state;
  logic [OPW-1:0]  op_q;
  logic [WW-1:0]   wait_q;
  logic            halted_q;
  logic            fault_q;
  logic [CNTW-1:0] retire_q;

  logic            op_hi_zero;
  logic [3:0]      op_lo;
  logic            is_store, is_load, is_alu, is_addi, is_beqz, is_halt, is_nop;
  logic [ALUW-1:0] alu_dec;

  logic            ir_write, pc_write, branch, alu_src;
  logic            mem_read, mem_write, mem_to_reg, reg_write;
  logic [ALUW-1:0] alu_op;

  // Any nonzero bit above the 4-bit opcode field turns the instruction into a NOP.
  assign op_hi_zero = ((op_q >> 4) == '0);
  assign op_lo      = op_q[3:0];

  // Classify the latched opcode and pick its ALU operation
  always_comb begin
    is_store = 1'b0;
    is_load  = 1'b0;
    is_alu   = 1'b0;
    is_addi  = 1'b0;
    is_beqz  = 1'b0;
    is_halt  = 1'b0;
    alu_dec  = ALU_PASS;
    if (op_hi_zero) begin
      case (op_lo)
        OP_STORE: begin is_store = 1'b1; alu_dec = ALU_ADD; end
        OP_LOAD:  begin is_load  = 1'b1; alu_dec = ALU_ADD; end
        OP_ADD:   begin is_alu   = 1'b1; alu_dec = ALU_ADD; end
        OP_SUB:   begin is_alu   = 1'b1; alu_dec = ALU_SUB; end
        OP_AND:   begin is_alu   = 1'b1; alu_dec = ALU_AND; end
        OP_XOR:   begin is_alu   = 1'b1; alu_dec = ALU_XOR; end
        OP_ADDI:  begin is_alu   = 1'b1; is_addi = 1'b1; alu_dec = ALU_ADD; end
        OP_BEQZ:  is_beqz = 1'b1;
        OP_HALT:  is_halt = 1'b1;
        default:  ;
      endcase
    end
    is_nop = !(is_store || is_load || is_alu || is_beqz || is_halt);
  end

  // Per-state datapath strobes; IRWrite, Branch and the store retire pulse follow live inputs
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_PASS;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    case (state)
      S_FETCH:  ir_write = bus.InstValid;
      S_DECODE: pc_write = is_nop;
      S_EXEC: begin
        alu_op  = alu_dec;
        alu_src = is_load || is_store;
        if (is_beqz) begin
          branch   = bus.Zero;
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        alu_op    = alu_dec;
        alu_src   = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        pc_write  = is_store && bus.MemReady;
      end
      S_WB: begin
        alu_op     = alu_dec;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = is_load;
        alu_src    = is_addi;
      end
      default: ;
    endcase
  end

  // Sequencer state, memory wait timer, sticky status and retire counter
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_FETCH;
      op_q     <= '0;
      wait_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      if (pc_write) retire_q <= retire_q + CNTW'(1);
      case (state)
        S_FETCH: begin
          if (bus.InstValid) begin
            op_q  <= bus.Opcode;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_halt) begin
            halted_q <= 1'b1;
            state    <= S_HALT;
          end else if (is_nop) begin
            state <= S_FETCH;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_load || is_store) begin
            wait_q <= '0;
            state  <= S_MEM;
          end else if (is_beqz) begin
            state <= S_FETCH;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          // A ready arriving on the last allowed cycle still completes the access.
          if (bus.MemReady) begin
            state <= is_load ? S_WB : S_FETCH;
          end else if (wait_q == WAIT_LAST) begin
            fault_q <= 1'b1;
            state   <= S_FAULT;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  ;
        S_FAULT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.Branch    = branch;
  assign bus.ALUSrc    = alu_src;
  assign bus.ALUOp     = alu_op;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.RegWrite  = reg_write;
  assign bus.Halted    = halted_q;
  assign bus.Fault     = fault_q;
  assign bus.RetireCnt = retire_q;

endmodule
